// File: rtl/wfg_wishbone_regbank.sv
// Multi-channel Wishbone register bank for the waveform-generator cores:
// per-channel CTRL, double-buffered CFG, STATUS and write-1-to-clear IRQ.
module wfg_wishbone_regbank #(
  parameter int BUSW       = 32,
  parameter int NUM_CH     = 4,
  parameter int SUBCYCLE_W = 16,
  parameter int SYNC_W     = 8,
  parameter int ACK_WAIT   = 0
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_we_i,
  input  logic [BUSW/8-1:0]              wbs_sel_i,
  input  logic [BUSW-1:0]                wbs_dat_i,
  input  logic [BUSW-1:0]                wbs_adr_i,
  output logic                           wbs_ack_o,
  output logic [BUSW-1:0]                wbs_dat_o,
  input  logic [NUM_CH-1:0]              update_i,
  input  logic [NUM_CH-1:0]              event_i,
  input  logic [NUM_CH-1:0]              busy_i,
  output logic [NUM_CH-1:0]              ctrl_en_q_o,
  output logic [NUM_CH*SUBCYCLE_W-1:0]   cfg_subcycle_q_o,
  output logic [NUM_CH*SYNC_W-1:0]       cfg_sync_q_o,
  output logic [NUM_CH-1:0]              commit_o,
  output logic                           irq_o
);

  localparam int CFG_W = SUBCYCLE_W + SYNC_W;
  localparam int NSEL = BUSW / 8;
  localparam logic [1:0] WAIT_N = 2'(ACK_WAIT);

  function automatic logic [BUSW-1:0] merge_lanes(input logic [BUSW-1:0] old,
                                                  input logic [BUSW-1:0] dat,
                                                  input logic [NSEL-1:0] sel);
    logic [BUSW-1:0] res;
    for (int b = 0; b < NSEL; b++) begin
      res[b*8 +: 8] = sel[b] ? dat[b*8 +: 8] : old[b*8 +: 8];
    end
    return res;
  endfunction

  logic [3:0] ch;
  logic [1:0] off;
  logic       mapped;
  logic       req;
  logic       fire;
  logic       waiting;
  logic [1:0] wait_cnt;
  logic       wr;
  logic       unused_adr;

  assign ch         = wbs_adr_i[7:4];
  assign off        = wbs_adr_i[3:2];
  assign unused_adr = ^wbs_adr_i[1:0];
  assign mapped     = (wbs_adr_i[BUSW-1:8] == '0) && ({1'b0, ch} < 5'(NUM_CH));
  assign req        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr         = fire & wbs_we_i & mapped;

  // An access completes on the edge that raises ack; waiting tracks ACK_WAIT.
  always_comb begin
    fire = 1'b0;
    if (req) begin
      if (waiting) fire = (wait_cnt == WAIT_N);
      else         fire = (ACK_WAIT == 0);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      waiting   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      wbs_ack_o <= fire;
      if (fire || !req) begin
        // completion, or stb/cyc dropped mid-wait (abort)
        waiting  <= 1'b0;
        wait_cnt <= '0;
      end else if (!waiting) begin
        waiting  <= 1'b1;
        wait_cnt <= 2'd1;
      end else begin
        wait_cnt <= wait_cnt + 2'd1;
      end
    end
  end

  logic [NUM_CH-1:0] en_q, ie_q, pending_q, flag_q, commit_q;
  logic [NUM_CH-1:0] ctrl_wr, cfg_wr, commit_req, w1c;
  logic [CFG_W-1:0]  shadow_q [NUM_CH];
  logic [CFG_W-1:0]  active_q [NUM_CH];

  always_comb begin
    ctrl_wr    = '0;
    cfg_wr     = '0;
    commit_req = '0;
    w1c        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_wr[c]    = wr && (ch == 4'(c)) && (off == 2'd0);
      cfg_wr[c]     = wr && (ch == 4'(c)) && (off == 2'd1);
      w1c[c]        = wr && (ch == 4'(c)) && (off == 2'd3) && wbs_sel_i[0] && wbs_dat_i[0];
      commit_req[c] = (ctrl_wr[c] & wbs_sel_i[0] & wbs_dat_i[1]) | (update_i[c] & pending_q[c]);
    end
  end

  // Active CFG always loads the pre-write shadow, so a racing CFG write stays pending.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      en_q      <= '0;
      ie_q      <= '0;
      pending_q <= '0;
      flag_q    <= '0;
      commit_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ctrl_wr[c] && wbs_sel_i[0]) begin
          en_q[c] <= wbs_dat_i[0];
          ie_q[c] <= wbs_dat_i[2];
        end
        if (cfg_wr[c])
          shadow_q[c] <= CFG_W'(merge_lanes(BUSW'(shadow_q[c]), wbs_dat_i, wbs_sel_i));
        if (commit_req[c])
          active_q[c] <= shadow_q[c];
        pending_q[c] <= cfg_wr[c] | (pending_q[c] & ~commit_req[c]);
        commit_q[c]  <= commit_req[c];
        flag_q[c]    <= event_i[c] | (flag_q[c] & ~w1c[c]);
      end
    end
  end

  logic [BUSW-1:0] rdata;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mapped && (ch == 4'(c))) begin
        case (off)
          2'd0: begin
            rdata[0] = en_q[c];
            rdata[2] = ie_q[c];
          end
          2'd1:    rdata[CFG_W-1:0] = shadow_q[c];
          2'd2:    rdata[1:0] = {pending_q[c], busy_i[c]};
          default: rdata[0] = flag_q[c];
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                wbs_dat_o <= '0;
    else if (fire)                 wbs_dat_o <= wbs_we_i ? '0 : rdata;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign cfg_subcycle_q_o[c*SUBCYCLE_W +: SUBCYCLE_W] = active_q[c][CFG_W-1:SYNC_W];
    assign cfg_sync_q_o[c*SYNC_W +: SYNC_W]             = active_q[c][SYNC_W-1:0];
  end

  assign ctrl_en_q_o = en_q;
  assign commit_o    = commit_q;
  assign irq_o       = |(flag_q & ie_q);

endmodule

// File: tb/tb_wfg_wishbone_regbank.sv
// Directed bench for wfg_wishbone_regbank: a zero-wait instance for register
// behaviour and an ACK_WAIT=2 instance for handshake latency and abort.
`timescale 1ns/1ps
module tb_wfg_wishbone_regbank;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic        stb [2];
  logic        cyc [2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic [31:0] dat_i [2];
  logic [31:0] adr [2];
  logic        ack [2];
  logic [31:0] dat_o [2];

  logic [3:0]  update_a, event_a, busy_a;
  logic [3:0]  ctrl_en_a, commit_a;
  logic [63:0] sub_a;
  logic [31:0] sync_a;
  logic        irq_a;

  logic [3:0]  zero_b;
  logic [3:0]  ctrl_en_b, commit_b;
  logic [63:0] sub_b;
  logic [31:0] sync_b;
  logic        irq_b;

  int checks = 0;
  int errors = 0;
  int commit_cnt [4] = '{default: 0};

  always #5 clk = ~clk;

  wfg_wishbone_regbank #(.ACK_WAIT(0)) dut_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
    .wbs_dat_i(dat_i[0]), .wbs_adr_i(adr[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(dat_o[0]),
    .update_i(update_a), .event_i(event_a), .busy_i(busy_a),
    .ctrl_en_q_o(ctrl_en_a), .cfg_subcycle_q_o(sub_a), .cfg_sync_q_o(sync_a),
    .commit_o(commit_a), .irq_o(irq_a)
  );

  wfg_wishbone_regbank #(.ACK_WAIT(2)) dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
    .wbs_dat_i(dat_i[1]), .wbs_adr_i(adr[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(dat_o[1]),
    .update_i(zero_b), .event_i(zero_b), .busy_i(zero_b),
    .ctrl_en_q_o(ctrl_en_b), .cfg_subcycle_q_o(sub_b), .cfg_sync_q_o(sync_b),
    .commit_o(commit_b), .irq_o(irq_b)
  );

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++)
      if (commit_a[c]) commit_cnt[c] <= commit_cnt[c] + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wb_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input logic w, input logic [3:0] upd,
                           input logic [3:0] evt, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd = '0;
    @(posedge clk); #1;
    adr[d] = a; dat_i[d] = wd; sel[d] = s; we[d] = w; stb[d] = 1'b1; cyc[d] = 1'b1;
    update_a = upd; event_a = evt;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      update_a = '0; event_a = '0;
      if (ack[d]) begin
        got = 1'b1;
        rd = dat_o[d];
      end
    end
    stb[d] = 1'b0; cyc[d] = 1'b0; we[d] = 1'b0;
    chk($sformatf("ack_d%0d_adr%0h", d, a), {63'd0, got}, 64'd1);
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] r;
    wb_access(d, a, wd, s, 1'b1, 4'h0, 4'h0, r);
  endtask

  task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    wb_access(d, a, 32'h0, 4'hF, 1'b0, 4'h0, 4'h0, r);
    chk(name, {32'd0, r}, {32'd0, exp});
  endtask

  task automatic pulse(input logic [3:0] upd, input logic [3:0] evt);
    @(posedge clk); #1;
    update_a = upd; event_a = evt;
    @(posedge clk); #1;
    update_a = '0; event_a = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [25];
    logic [31:0] r;
    int acks, lat;

    vecs[0]  = '{32'h000, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[1]  = '{32'h014, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[2]  = '{32'h014, 32'h00ABCDEF, 4'h2, 1'b1, 32'h0};
    vecs[3]  = '{32'h014, 32'h0,        4'hF, 1'b0, 32'h0000CD00};
    vecs[4]  = '{32'h018, 32'h0,        4'hF, 1'b0, 32'h2};
    vecs[5]  = '{32'h024, 32'h00123456, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{32'h020, 32'h3,        4'h1, 1'b1, 32'h0};
    vecs[7]  = '{32'h020, 32'h0,        4'hF, 1'b0, 32'h1};
    vecs[8]  = '{32'h028, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[9]  = '{32'h024, 32'h0,        4'hF, 1'b0, 32'h00123456};
    vecs[10] = '{32'h028, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    vecs[11] = '{32'h028, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[12] = '{32'h030, 32'h4,        4'h1, 1'b1, 32'h0};
    vecs[13] = '{32'h030, 32'h0,        4'hF, 1'b0, 32'h4};
    vecs[14] = '{32'h020, 32'hFF,       4'h0, 1'b1, 32'h0};
    vecs[15] = '{32'h020, 32'h0,        4'hF, 1'b0, 32'h1};
    vecs[16] = '{32'h004, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    vecs[17] = '{32'h104, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[18] = '{32'h044, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[19] = '{32'h004, 32'h0,        4'hF, 1'b0, 32'h00FFFFFF};
    vecs[20] = '{32'h104, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[21] = '{32'h040, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[22] = '{32'h007, 32'h0,        4'hF, 1'b0, 32'h00FFFFFF};
    vecs[23] = '{32'h000, 32'h0000FF07, 4'h2, 1'b1, 32'h0};
    vecs[24] = '{32'h000, 32'h0,        4'hF, 1'b0, 32'h0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      stb[d] = 1'b0; cyc[d] = 1'b0; we[d] = 1'b0; sel[d] = '0; dat_i[d] = '0; adr[d] = '0;
    end
    update_a = '0; event_a = '0; busy_a = '0; zero_b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_a", {63'd0, ack[0]}, 64'd0);
    chk("rst_ack_b", {63'd0, ack[1]}, 64'd0);
    chk("rst_en", {60'd0, ctrl_en_a}, 64'd0);
    chk("rst_sub", sub_a, 64'd0);
    chk("rst_sync", {32'd0, sync_a}, 64'd0);
    chk("rst_irq", {62'd0, irq_a, irq_b}, 64'd0);
    chk("rst_dat", {32'd0, dat_o[0]}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      wb_access(0, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, 4'h0, 4'h0, r);
      if (!vecs[i].we) chk($sformatf("vec%0d", i), {32'd0, r}, {32'd0, vecs[i].exp});
    end

    chk("en_after_tbl", {60'd0, ctrl_en_a}, 64'h4);
    chk("sub_ch2", {48'd0, sub_a[47:32]}, 64'h1234);
    chk("sync_ch2", {56'd0, sync_a[23:16]}, 64'h56);
    chk("active_ch1_zero", {40'd0, sub_a[31:16], sync_a[15:8]}, 64'd0);
    chk("commit_ch2_once", commit_cnt[2], 1);
    chk("commit_ch1_none", commit_cnt[1], 0);

    // COMMIT with nothing pending still loads and pulses; EN cleared
    wr(0, 32'h020, 32'h2, 4'h1);
    rd_chk(0, 32'h020, 32'h0, "ctrl_ch2_commit_only");
    chk("commit_ch2_twice", commit_cnt[2], 2);
    chk("en_cleared", {60'd0, ctrl_en_a}, 64'h0);
    chk("sub_ch2_kept", {48'd0, sub_a[47:32]}, 64'h1234);

    // shadow race on ch0
    wr(0, 32'h004, 32'h11, 4'hF);
    wb_access(0, 32'h004, 32'h77, 4'hF, 1'b1, 4'h1, 4'h0, r);
    chk("race_sync", {56'd0, sync_a[7:0]}, 64'h11);
    chk("race_sub", {48'd0, sub_a[15:0]}, 64'h0);
    rd_chk(0, 32'h004, 32'h77, "race_shadow");
    rd_chk(0, 32'h008, 32'h2, "race_pending");
    chk("race_commit", commit_cnt[0], 1);
    pulse(4'h1, 4'h0);
    rd_chk(0, 32'h008, 32'h0, "upd_clears_pending");
    chk("upd_sync", {56'd0, sync_a[7:0]}, 64'h77);
    chk("upd_commit", commit_cnt[0], 2);
    pulse(4'h1, 4'h0);
    rd_chk(0, 32'h004, 32'h77, "idle_upd_shadow");
    chk("idle_upd_no_commit", commit_cnt[0], 2);

    busy_a = 4'b0010;
    rd_chk(0, 32'h018, 32'h3, "status_busy_pending");
    busy_a = '0;

    // IRQ on ch3 (IE=1) and ch1 (IE=0)
    chk("irq_idle", {63'd0, irq_a}, 64'd0);
    pulse(4'h0, 4'h8);
    chk("irq_set", {63'd0, irq_a}, 64'd1);
    rd_chk(0, 32'h03C, 32'h1, "flag_set");
    wb_access(0, 32'h03C, 32'h1, 4'h1, 1'b1, 4'h0, 4'h8, r);
    chk("irq_set_wins", {63'd0, irq_a}, 64'd1);
    wr(0, 32'h03C, 32'h1, 4'h2);
    chk("irq_w1c_nolane0", {63'd0, irq_a}, 64'd1);
    wr(0, 32'h03C, 32'h1, 4'h1);
    chk("irq_cleared", {63'd0, irq_a}, 64'd0);
    rd_chk(0, 32'h03C, 32'h0, "flag_cleared");
    pulse(4'h0, 4'h2);
    chk("irq_masked", {63'd0, irq_a}, 64'd0);
    rd_chk(0, 32'h01C, 32'h1, "flag_ch1_masked");

    // ACK_WAIT=2 instance: aborted write has no ack and no effect
    @(posedge clk); #1;
    adr[1] = 32'h0; dat_i[1] = 32'h1; sel[1] = 4'h1; we[1] = 1'b1; stb[1] = 1'b1; cyc[1] = 1'b1;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
    end
    stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_no_write", {60'd0, ctrl_en_b}, 64'd0);

    // latency and width of ack on an unmapped read
    @(posedge clk); #1;
    adr[1] = 32'h100; sel[1] = 4'hF; we[1] = 1'b0; stb[1] = 1'b1; cyc[1] = 1'b1;
    acks = 0; lat = 0; r = 32'hDEADBEEF;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (ack[1]) begin
        acks++;
        if (lat == 0) begin
          lat = i;
          r = dat_o[1];
          stb[1] = 1'b0; cyc[1] = 1'b0;
        end
      end
    end
    stb[1] = 1'b0; cyc[1] = 1'b0;
    chk("wait2_latency", lat, 3);
    chk("wait2_ack_width", acks, 1);
    chk("wait2_unmapped_data", {32'd0, r}, 64'd0);
    wr(1, 32'h000, 32'h1, 4'h1);
    chk("wait2_en", {60'd0, ctrl_en_b}, 64'h1);
    rd_chk(1, 32'h000, 32'h1, "wait2_ctrl_read");

    // reset asserted mid-transaction
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      adr[d] = 32'h020; sel[d] = 4'hF; we[d] = 1'b0; stb[d] = 1'b1; cyc[d] = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_irq", {63'd0, irq_a}, 64'd0);
    chk("midrst_en", {56'd0, ctrl_en_a, ctrl_en_b}, 64'd0);
    chk("midrst_cfg", {sub_a[47:0], sync_a[15:0]}, 64'd0);
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack[0] || ack[1]) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    for (int d = 0; d < 2; d++) begin
      stb[d] = 1'b0; cyc[d] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_chk(0, 32'h01C, 32'h0, "post_rst_flag1");
    rd_chk(0, 32'h030, 32'h0, "post_rst_ie3");
    rd_chk(0, 32'h004, 32'h0, "post_rst_shadow0");
    rd_chk(0, 32'h008, 32'h0, "post_rst_status0");
    rd_chk(1, 32'h000, 32'h0, "post_rst_ctrl_b");
    chk("post_rst_irq", {63'd0, irq_a}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
